// File: rtl/aes_pkg.sv
// Shared AES constants, key-expansion FSM state type and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1B;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_e;

  // Multiply by x in GF(2^8); drives the Rcon sequence and MixColumns.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: 8-bit combinational lookup shared by SubWord and SubBytes.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Element 0 sits in the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/round_key_gen.sv
// Sequential AES-128 key expansion: loads a cipher key and hands out round
// keys 0..NR one per accepted valid/ready transfer.
module round_key_gen
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic         xfer;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_w[8*gi +: 8]),
      .data_o (sub_w[8*gi +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign xfer = (state_q == GEN) && rk_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = key_in;
          idx_d   = '0;
          rcon_d  = RCON_INIT;
          state_d = GEN;
        end
      end
      GEN: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            // Final key accepted: rk/idx keep their last values.
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rk_d   = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk_out   = rk_q;
  assign rk_index = idx_q;
  assign rk_valid = (state_q == GEN);
  assign busy     = (state_q == GEN);
  assign done     = done_q;

endmodule

// File: tb/tb_round_key_gen.sv
// Self-checking bench for round_key_gen against a FIPS-197 key-schedule model.
module tb_round_key_gen;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  round_key_gen #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_out   (rk_out),
    .rk_index (rk_index),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0]   sbox_m [0:255];
  logic [127:0] exp_k  [0:10];
  logic [127:0] got_k  [0:10];
  logic [3:0]   got_i  [0:10];
  int got_n, extra, done_seen, done_cyc, first_valid, unstable, bad_done, injected;

  // ---------------- reference model (GF(2^8) arithmetic, FIPS-197 KeyExpansion)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers
  task automatic kick(input logic [127:0] key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
  endtask

  // Records every accepted key; optionally pulses start mid-run or chains a restart on done.
  task automatic collect(input int ready_pct, input int inject_idx, input bit chain,
                         input logic [127:0] chain_key);
    logic [127:0] prev_k;
    logic [3:0]   prev_i;
    bit           prev_stall;
    got_n = 0; extra = 0; done_seen = 0; done_cyc = -1; first_valid = -1;
    unstable = 0; bad_done = 0; injected = 0;
    prev_stall = 1'b0; prev_k = '0; prev_i = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_seen++;
        if (done_cyc < 0) done_cyc = c;
        if (rk_valid !== 1'b0 || busy !== 1'b0) bad_done++;
      end
      if (prev_stall && (rk_out !== prev_k || rk_index !== prev_i)) unstable++;
      if (rk_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (inject_idx >= 0 && injected == 0 && rk_valid === 1'b1 && rk_index == inject_idx[3:0]) begin
        start    = 1'b1;
        key_in   = '0;
        injected = 1;
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_valid === 1'b1 && rk_ready) begin
        if (got_n < 11) begin
          got_k[got_n] = rk_out;
          got_i[got_n] = rk_index;
          got_n++;
        end else extra++;
      end
      prev_stall = (rk_valid === 1'b1) && !rk_ready;
      prev_k = rk_out;
      prev_i = rk_index;
      if (done_cyc >= 0) begin
        if (chain) begin
          start  = 1'b1;
          key_in = chain_key;
          break;
        end
        if (c >= done_cyc + 3) break;
      end
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({rk_out, rk_index, rk_valid, busy, done} !== {128'h0, 4'h0, 3'b000})
      $display("FAIL reset_state: got out=%h idx=%0d v=%b b=%b d=%b want all zero",
               rk_out, rk_index, rk_valid, busy, done);
    else n_pass++;
    start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_total++;
    if ({rk_out, rk_valid, busy} !== {128'h0, 2'b00})
      $display("FAIL reset_beats_start: got out=%h v=%b b=%b want 0/0/0", rk_out, rk_valid, busy);
    else n_pass++;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips_vector();
    expand(FIPS_KEY);
    kick(FIPS_KEY);
    collect(100, -1, 1'b0, '0);
    n_total++;
    if (first_valid !== 0) $display("FAIL fips_latency: got first valid cycle %0d want 0", first_valid);
    else n_pass++;
    n_total++;
    if (got_n !== 11 || extra !== 0) $display("FAIL fips_count: got %0d keys (+%0d) want 11", got_n, extra);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r] || got_i[r] !== 4'(r))
        $display("FAIL fips_key%0d: got idx=%0d %h want idx=%0d %h", r, got_i[r], got_k[r], r, exp_k[r]);
      else n_pass++;
    end
    n_total++;
    if (got_k[0] !== FIPS_KEY || got_k[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        got_k[2] !== 128'hf2c295f27a96b9435935807a7359f67f ||
        got_k[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL fips_literal: got k1=%h k2=%h k10=%h want a0fafe17.. f2c295f2.. d014f9a8..",
               got_k[1], got_k[2], got_k[10]);
    else n_pass++;
    n_total++;
    if (done_seen !== 1 || done_cyc !== 11 || bad_done !== 0)
      $display("FAIL fips_done: got count=%0d cycle=%0d badflags=%0d want 1/11/0", done_seen, done_cyc, bad_done);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    expand(FIPS_KEY);
    kick(FIPS_KEY);
    collect(30, -1, 1'b0, '0);
    n_total++;
    if (got_n !== 11 || extra !== 0) $display("FAIL bp_count: got %0d keys (+%0d) want 11", got_n, extra);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r] || got_i[r] !== 4'(r))
        $display("FAIL bp_key%0d: got idx=%0d %h want idx=%0d %h", r, got_i[r], got_k[r], r, exp_k[r]);
      else n_pass++;
    end
    n_total++;
    if (unstable !== 0) $display("FAIL bp_stable: got %0d changes under stall want 0", unstable);
    else n_pass++;
    n_total++;
    if (done_seen !== 1) $display("FAIL bp_done: got %0d pulses want 1", done_seen);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    logic [127:0] key;
    key = {$urandom, $urandom, $urandom, $urandom};
    expand(key);
    kick(key);
    collect(100, 4, 1'b0, '0);
    n_total++;
    if (injected !== 1) $display("FAIL busy_inject: got injected=%0d want 1 (index 4 never valid)", injected);
    else n_pass++;
    n_total++;
    if (got_n !== 11 || extra !== 0) $display("FAIL busy_count: got %0d keys (+%0d) want 11", got_n, extra);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r] || got_i[r] !== 4'(r))
        $display("FAIL busy_key%0d: got idx=%0d %h want idx=%0d %h", r, got_i[r], got_k[r], r, exp_k[r]);
      else n_pass++;
    end
    n_total++;
    if (done_seen !== 1) $display("FAIL busy_done: got %0d pulses want 1", done_seen);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [127:0] key;
    bit           hit;
    int           spurious;
    key = {$urandom, $urandom, $urandom, $urandom};
    kick(key);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      rk_ready = 1'b1;
      if (rk_valid === 1'b1 && rk_index == 4'd6) begin
        hit = 1'b1;
        break;
      end
    end
    n_total++;
    if (!hit) $display("FAIL mrst_reach6: got index %0d want 6 within 40 cycles", rk_index);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({rk_out, rk_index, rk_valid, busy, done} !== {128'h0, 4'h0, 3'b000})
      $display("FAIL mrst_state: got out=%h idx=%0d v=%b b=%b d=%b want all zero",
               rk_out, rk_index, rk_valid, busy, done);
    else n_pass++;
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    n_total++;
    if (spurious !== 0) $display("FAIL mrst_nodone: got %0d done pulses want 0", spurious);
    else n_pass++;
    key = {$urandom, $urandom, $urandom, $urandom};
    expand(key);
    kick(key);
    collect(100, -1, 1'b0, '0);
    n_total++;
    if (got_n !== 11) $display("FAIL mrst_count: got %0d keys want 11", got_n);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r] || got_i[r] !== 4'(r))
        $display("FAIL mrst_key%0d: got idx=%0d %h want idx=%0d %h", r, got_i[r], got_k[r], r, exp_k[r]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_key();
    expand('0);
    kick('0);
    collect(100, -1, 1'b0, '0);
    n_total++;
    if (got_n !== 11) $display("FAIL zero_count: got %0d keys want 11", got_n);
    else n_pass++;
    n_total++;
    if (got_k[1] !== 128'h62636363626363636263636362636363 ||
        got_k[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
      $display("FAIL zero_literal: got k1=%h k10=%h want 62636363.. b4ef5bcb..", got_k[1], got_k[10]);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r])
        $display("FAIL zero_key%0d: got %h want %h", r, got_k[r], exp_k[r]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] key_a;
    logic [127:0] key_b;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    expand(key_a);
    kick(key_a);
    collect(100, -1, 1'b1, key_b);
    n_total++;
    if (got_n !== 11 || done_seen !== 1)
      $display("FAIL b2b_first: got %0d keys %0d done want 11/1", got_n, done_seen);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r])
        $display("FAIL b2b_a_key%0d: got %h want %h", r, got_k[r], exp_k[r]);
      else n_pass++;
    end
    expand(key_b);
    collect(100, -1, 1'b0, '0);
    n_total++;
    if (first_valid !== 0 || got_k[0] !== key_b)
      $display("FAIL b2b_restart: got first valid %0d key0 %h want 0 %h", first_valid, got_k[0], key_b);
    else n_pass++;
    n_total++;
    if (got_n !== 11 || done_seen !== 1)
      $display("FAIL b2b_second: got %0d keys %0d done want 11/1", got_n, done_seen);
    else n_pass++;
    for (int r = 0; r < got_n; r++) begin
      n_total++;
      if (got_k[r] !== exp_k[r] || got_i[r] !== 4'(r))
        $display("FAIL b2b_b_key%0d: got idx=%0d %h want idx=%0d %h", r, got_i[r], got_k[r], r, exp_k[r]);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_backpressure();
    test_start_while_busy();
    test_mid_reset();
    test_zero_key();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/round_key_gen.md
# round_key_gen

Sequential AES-128 key-expansion engine that sits directly upstream of the round datapath. It loads a 128-bit cipher key and emits round keys 0 through 10 one at a time over a valid/ready handshake, in the form the round stage consumes on its `key` input. Each round key is computed from the previous one in a single cycle. The engine runs in lockstep with the iterative round controller, which pulls one key per round.

## Interface
Parameters:
- `NR`, default 10: number of rounds; the last round key index equals `NR`. Only 10 (AES-128) is supported.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to load `key_in`. Sampled only in IDLE.
- `key_in`  in  128: cipher key; byte 0 is in `[127:120]` (FIPS-197 order).
- `rk_out`  out  128: current round key.
- `rk_index`  out  4: round number of `rk_out`, 0..10.
- `rk_valid`  out  1: `rk_out`/`rk_index` are valid.
- `rk_ready`  in  1: consumer accepts the key; a transfer occurs when `rk_valid && rk_ready`.
- `busy`  out  1: high while in the GEN state.
- `done`  out  1: one-cycle pulse after key 10 is accepted.

## Operation
- States: IDLE and GEN.
- **IDLE**
  - `start=1`: register `rk_out<=key_in`, `rk_index<=0`, `rcon<=8'h01`, `rk_valid<=1`, `busy<=1`, then go to GEN.
  - `start=0`: hold.
- **GEN, transfer with `rk_index<10`**
  - `rk_out<=next_key(rk_out, rcon)`.
  - `rk_index<=rk_index+1`.
  - `rcon<=xtime(rcon)`, where xtime is a left shift that XORs `8'h1B` if bit 7 was set. The sequence is 01,02,04,08,10,20,40,80,1B,36.
- **GEN, transfer with `rk_index==10`**
  - `rk_valid<=0`, `busy<=0`, `done<=1` for one cycle.
  - Go to IDLE.
  - `rk_out` and `rk_index` keep their last values.
- **GEN, no transfer**: all registers hold. `rk_out` must stay stable while `rk_valid && !rk_ready`.
- `next_key` (combinational):
  - Words: `w0=[127:96]`, `w1=[95:64]`, `w2=[63:32]`, `w3=[31:0]`.
  - `t = SubWord({w3[23:0],w3[31:24]}) ^ {rcon,24'h0}`.
  - `w0'=w0^t`, `w1'=w1^w0'`, `w2'=w2^w1'`, `w3'=w3^w2'`.
  - SubWord applies the AES S-box to each of the 4 bytes.
- `start` asserted while in GEN is ignored; the sequence in progress is unaffected.
- `start` and `rst` asserted together: reset wins.

## Timing
- Reset values: `rk_out=0`, `rk_index=0`, `rk_valid=0`, `busy=0`, `done=0`. Internally `rcon=8'h01` and state is IDLE.
- Reset in the middle of a sequence aborts it. All outputs return to their reset values on the next edge, and no `done` pulse is issued.
- Latency: `start` sampled at edge N gives key 0 valid after edge N.
- With `rk_ready` held high, keys 0..10 appear on 11 consecutive cycles. `done` pulses in the cycle after key 10 is accepted.
- Earliest restart: `start` may be asserted in the same cycle that `done` is high, because the block is already in IDLE.
- Throughput is one round key per cycle. The critical path is S-box → XOR chain (4 XORs deep on `w3'`).
- `rk_index` never exceeds 10. Nothing wraps; the sequence terminates.

## Structure
- Shared package `aes_pkg`:
  - constant `AES_NR=10`
  - the Rcon initial value `8'h01` and reduction polynomial `8'h1B`
  - state enum {IDLE, GEN}
  - `xtime` function, also reused by mixcolumns
- Sub-module `aes_sbox`: 8-bit in / 8-bit out combinational lookup. Instantiate it four times for SubWord; the same module also serves the subbytes stage.

## Test plan
- **FIPS-197 A.1 vector**: key `2b7e151628aed2a6abf7158809cf4f3c` with `rk_ready=1`.
  - Index 0 shows the key unchanged.
  - Index 1 = `a0fafe1788542cb123a339392a6c7605`.
  - Index 2 = `f2c295f27a96b9435935807a7359f67f`.
  - Index 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `done` pulses exactly once, 11 cycles after the first valid.
- **Backpressure**: same key, `rk_ready` random at 30% duty.
  - The key sequence is identical to the vector above.
  - `rk_out`/`rk_index` never change while `valid && !ready`.
- **Start while busy**: pulse `start` with key `000…0` during index 4.
  - The sequence continues with the original key's values.
- **Mid-sequence reset**: assert `rst` at index 6.
  - Next cycle: `rk_valid=0`, `busy=0`, `rk_out=0`, no `done`.
  - A new `start` restarts from index 0 with Rcon `01`.
- **All-zero key**: key index 1 = `62636363626363636263636362636363`; index 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- **Back-to-back**: `start` in the cycle where `done=1`.
  - Key 0 of the second run is valid on the next cycle.
